// File: rtl/text_cmd_pkg.sv
// rtl/text_cmd_pkg.sv - opcodes, request encoding, FSM states and FIFO entry layout for the text command issuer
package text_cmd_pkg;

  localparam int X_W = 6;
  localparam int Y_W = 5;

  localparam logic [7:0] OP_SET_X   = 8'd10;
  localparam logic [7:0] OP_SET_Y   = 8'd11;
  localparam logic [7:0] OP_WR_TEX  = 8'd12;
  localparam logic [7:0] OP_WR_PAL  = 8'd13;
  localparam logic [7:0] OP_CTRL_F4 = 8'd244;
  localparam logic [7:0] OP_CTRL_FC = 8'd252;
  localparam logic [7:0] OP_FLUSH   = 8'd253;
  localparam logic [7:0] OP_CTRL_FE = 8'd254;

  typedef enum logic [1:0] {
    REQ_PUT   = 2'd0,
    REQ_FLUSH = 2'd1,
    REQ_RAW   = 2'd2,
    REQ_RSVD  = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_X,
    S_SEND_Y,
    S_SEND_CHR,
    S_SEND_PAL,
    S_SEND_FLUSH,
    S_WAIT_IRQ
  } state_e;

  // PUT keeps {8'h00, char, pal} in payload; RAW keeps the whole command word there.
  typedef struct packed {
    req_op_e        op;
    logic [23:0]    payload;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } req_t;

  function automatic logic [23:0] cmd_word(input logic [7:0] opcode, input logic [15:0] data);
    return {opcode, data};
  endfunction

endpackage

// File: rtl/text_req_fifo.sv
// rtl/text_req_fifo.sv - request FIFO with registered count; read data is the current head entry
module text_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/text_cmd_issuer.sv
// rtl/text_cmd_issuer.sv - serialises queued text requests into 24-bit command words with a start strobe
module text_cmd_issuer
  import text_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int FLUSH_TIMEOUT = 4095
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [X_W-1:0] req_x,
  input  logic [Y_W-1:0] req_y,
  input  logic [7:0]     req_char,
  input  logic [7:0]     req_pal,
  input  logic [23:0]    req_raw,
  output logic [23:0]    out,
  output logic           start,
  input  logic           done_irq,
  output logic           phase,
  output logic           busy,
  output logic           timeout_err
);

  localparam logic [11:0] TMO_LOAD = 12'(FLUSH_TIMEOUT);

  req_t wr_entry, head;
  logic fifo_full, fifo_empty, push, pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  state_e         state_q, state_d;
  logic [23:0]    out_q, out_d;
  logic           start_q, start_d;
  logic           phase_q, phase_d;
  logic           terr_q, terr_d;
  logic [11:0]    cnt_q, cnt_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [7:0]     chr_q, chr_d;
  logic [7:0]     pal_q, pal_d;

  logic head_is_flush, head_is_plain_raw, dispatch_ok;

  always_comb begin
    wr_entry.op      = req_op_e'(req_op);
    wr_entry.payload = (req_op_e'(req_op) == REQ_RAW) ? req_raw : {8'h00, req_char, req_pal};
    wr_entry.x       = req_x;
    wr_entry.y       = req_y;
  end

  assign req_ready = !fifo_full && !rst;
  assign push      = req_valid && req_ready;

  text_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_is_flush = (head.op == REQ_FLUSH) ||
                         ((head.op == REQ_RAW) && (head.payload[23:16] == OP_FLUSH));
  assign head_is_plain_raw = (head.op == REQ_RAW) && !head_is_flush;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    start_d     = 1'b0;
    phase_d     = phase_q;
    terr_d      = terr_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    chr_d       = chr_q;
    pal_d       = pal_q;
    pop         = 1'b0;
    dispatch_ok = 1'b0;

    case (state_q)
      S_IDLE: dispatch_ok = !fifo_empty;
      S_SEND_X: begin
        out_d   = cmd_word(OP_SET_X, {7'b0, x_q, 3'b0});
        start_d = 1'b1;
        state_d = S_SEND_Y;
      end
      S_SEND_Y: begin
        out_d   = cmd_word(OP_SET_Y, {8'b0, y_q, 3'b0});
        start_d = 1'b1;
        state_d = S_SEND_CHR;
      end
      S_SEND_CHR: begin
        out_d   = cmd_word(OP_WR_TEX, {8'b0, chr_q});
        start_d = 1'b1;
        state_d = S_SEND_PAL;
      end
      S_SEND_PAL: begin
        out_d   = cmd_word(OP_WR_PAL, {8'b0, pal_q});
        start_d = 1'b1;
        state_d = S_IDLE;
        // A plain RAW would collide with this word on the output register; it waits one cycle.
        dispatch_ok = !fifo_empty && !head_is_plain_raw;
      end
      S_SEND_FLUSH: begin
        out_d   = cmd_word(OP_FLUSH, 16'h0000);
        start_d = 1'b1;
        phase_d = !phase_q;
        cnt_d   = TMO_LOAD;
        state_d = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (done_irq) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 12'd1;
          if (cnt_q <= 12'd1) begin
            cnt_d   = 12'd0;
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (dispatch_ok) begin
      pop = 1'b1;
      if (head.op == REQ_PUT) begin
        x_d     = head.x;
        y_d     = head.y;
        chr_d   = head.payload[15:8];
        pal_d   = head.payload[7:0];
        state_d = S_SEND_X;
      end else if (head_is_flush) begin
        state_d = S_SEND_FLUSH;
      end else if (head.op == REQ_RAW) begin
        out_d   = head.payload;
        start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      start_q <= 1'b0;
      phase_q <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      chr_q   <= '0;
      pal_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      start_q <= start_d;
      phase_q <= phase_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      chr_q   <= chr_d;
      pal_q   <= pal_d;
    end
  end

  assign out         = out_q;
  assign start       = start_q;
  assign phase       = phase_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_text_cmd_issuer.sv
// tb/tb_text_cmd_issuer.sv - directed self-checking bench for text_cmd_issuer
module tb_text_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [5:0]  req_x;
  logic [4:0]  req_y;
  logic [7:0]  req_char;
  logic [7:0]  req_pal;
  logic [23:0] req_raw;
  logic [23:0] out;
  logic        start;
  logic        done_irq;
  logic        phase;
  logic        busy;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  int n_start;

  text_cmd_issuer #(.FIFO_DEPTH(4), .FLUSH_TIMEOUT(4095)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_char    (req_char),
    .req_pal     (req_pal),
    .req_raw     (req_raw),
    .out         (out),
    .start       (start),
    .done_irq    (done_irq),
    .phase       (phase),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input logic [23:0] exp);
    check({tag, ".start"}, {31'b0, start}, 32'd1);
    check({tag, ".out"}, {8'b0, out}, {8'b0, exp});
  endtask

  task automatic drive_put(input logic [5:0] x, input logic [4:0] y, input logic [7:0] c, input logic [7:0] p);
    req_valid = 1'b1; req_op = 2'd0; req_x = x; req_y = y; req_char = c; req_pal = p;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [23:0] raw);
    req_valid = 1'b1; req_op = op; req_raw = raw;
  endtask

  logic [23:0] exp_words [8];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0;
    req_char = '0; req_pal = '0; req_raw = '0; done_irq = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst.out", {8'b0, out}, 32'h0);
    check("rst.start", {31'b0, start}, 32'd0);
    check("rst.phase", {31'b0, phase}, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.timeout_err", {31'b0, timeout_err}, 32'd0);
    check("rst.req_ready", {31'b0, req_ready}, 32'd1);

    // PUT x=5 y=7: first word two edges after acceptance
    drive_put(6'd5, 5'd7, 8'h41, 8'h0C);
    tick();
    req_valid = 1'b0;
    check("put1.e0_start", {31'b0, start}, 32'd0);
    tick();
    check("put1.e1_start", {31'b0, start}, 32'd0);
    check("put1.e1_busy", {31'b0, busy}, 32'd1);
    tick(); check_cmd("put1.setx", 24'h0A0028);
    tick(); check_cmd("put1.sety", 24'h0B0038);
    tick(); check_cmd("put1.tex", 24'h0C0041);
    tick(); check_cmd("put1.pal", 24'h0D000C);
    tick();
    check("put1.end_start", {31'b0, start}, 32'd0);
    check("put1.end_busy", {31'b0, busy}, 32'd0);

    // FLUSH then PUT back-to-back, done_irq 1376 cycles after the 253 word
    drive_op(2'd1, 24'h0);
    tick();
    drive_put(6'd1, 5'd2, 8'h55, 8'h66);
    tick();
    req_valid = 1'b0;
    tick();
    check_cmd("flush1.word", 24'hFD0000);
    check("flush1.phase", {31'b0, phase}, 32'd1);
    n_start = 0;
    for (int i = 0; i < 1375; i++) begin
      tick();
      if (start) n_start++;
    end
    check("flush1.no_start_in_wait", n_start, 0);
    check("flush1.busy_in_wait", {31'b0, busy}, 32'd1);
    done_irq = 1'b1;
    tick();
    done_irq = 1'b0;
    check("flush1.d0_start", {31'b0, start}, 32'd0);
    tick();
    check("flush1.d1_start", {31'b0, start}, 32'd0);
    tick(); check_cmd("put2.setx", 24'h0A0008);
    tick(); check_cmd("put2.sety", 24'h0B0010);
    tick(); check_cmd("put2.tex", 24'h0C0055);
    tick(); check_cmd("put2.pal", 24'h0D0066);
    check("put2.phase", {31'b0, phase}, 32'd1);
    check("put2.no_timeout", {31'b0, timeout_err}, 32'd0);
    tick();

    // Reserved op is dropped silently, following RAW still issues
    drive_op(2'd3, 24'h0D1111);
    tick();
    drive_op(2'd2, 24'h0E00AA);
    tick();
    req_valid = 1'b0;
    check("rsvd.no_start", {31'b0, start}, 32'd0);
    tick(); check_cmd("rsvd.raw_after", 24'h0E00AA);
    tick();
    check("rsvd.end_start", {31'b0, start}, 32'd0);
    check("rsvd.end_busy", {31'b0, busy}, 32'd0);

    // Fill FIFO while stalled in WAIT_IRQ
    drive_op(2'd1, 24'h0);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check_cmd("full.flush_word", 24'hFD0000);
    check("full.phase", {31'b0, phase}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check("full.ready_before_push", {31'b0, req_ready}, 32'd1);
      drive_op(2'd2, 24'h0E0000 | 24'(i));
      tick();
    end
    check("full.ready_low", {31'b0, req_ready}, 32'd0);
    drive_op(2'd2, 24'h0E00FF);
    tick(); tick();
    check("full.ready_still_low", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    done_irq = 1'b1;
    tick();
    done_irq = 1'b0;
    check("full.d0_start", {31'b0, start}, 32'd0);
    tick();
    check_cmd("full.drain1", 24'h0E0001);
    check("full.ready_after_pop", {31'b0, req_ready}, 32'd1);
    drive_op(2'd2, 24'h0E0005);
    tick(); check_cmd("full.drain2", 24'h0E0002);
    drive_op(2'd2, 24'h0E0006);
    tick(); check_cmd("full.drain3", 24'h0E0003);
    req_valid = 1'b0;
    tick(); check_cmd("full.drain4", 24'h0E0004);
    tick(); check_cmd("full.drain5", 24'h0E0005);
    tick(); check_cmd("full.drain6", 24'h0E0006);
    tick();
    check("full.end_start", {31'b0, start}, 32'd0);
    check("full.end_busy", {31'b0, busy}, 32'd0);

    // Flush timeout exactly 4095 cycles after the 253 word
    drive_op(2'd1, 24'h0);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check_cmd("tmo.flush_word", 24'hFD0000);
    check("tmo.phase", {31'b0, phase}, 32'd1);
    repeat (4094) tick();
    check("tmo.not_yet", {31'b0, timeout_err}, 32'd0);
    check("tmo.busy_before", {31'b0, busy}, 32'd1);
    tick();
    check("tmo.set", {31'b0, timeout_err}, 32'd1);
    check("tmo.busy_after", {31'b0, busy}, 32'd0);

    // RAW verbatim, then RAW 253 acts as a flush
    drive_op(2'd2, 24'h0F1234);
    tick();
    req_valid = 1'b0;
    tick(); check_cmd("raw.verbatim", 24'h0F1234);
    tick();
    check("raw.one_cycle", {31'b0, start}, 32'd0);
    drive_op(2'd2, 24'hFD0000);
    tick();
    req_valid = 1'b0;
    tick();
    check("rawflush.pop_no_start", {31'b0, start}, 32'd0);
    tick(); check_cmd("rawflush.word", 24'hFD0000);
    check("rawflush.phase", {31'b0, phase}, 32'd0);
    check("rawflush.err_sticky", {31'b0, timeout_err}, 32'd1);
    done_irq = 1'b1;
    tick();
    done_irq = 1'b0;
    check("rawflush.idle", {31'b0, busy}, 32'd0);

    // Two PUTs back-to-back with no gap; x=43 passed through unchecked
    drive_put(6'd43, 5'd0, 8'h12, 8'h34);
    tick();
    drive_put(6'd0, 5'd31, 8'h56, 8'h78);
    tick();
    req_valid = 1'b0;
    exp_words[0] = 24'h0A0158; exp_words[1] = 24'h0B0000;
    exp_words[2] = 24'h0C0012; exp_words[3] = 24'h0D0034;
    exp_words[4] = 24'h0A0000; exp_words[5] = 24'h0B00F8;
    exp_words[6] = 24'h0C0056; exp_words[7] = 24'h0D0078;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_cmd($sformatf("b2b.word%0d", i), exp_words[i]);
    end
    tick();
    check("b2b.end_start", {31'b0, start}, 32'd0);

    // Reset while in SEND_Y
    drive_put(6'd5, 5'd7, 8'h41, 8'h0C);
    tick();
    drive_put(6'd9, 5'd9, 8'h99, 8'h99);
    tick();
    req_valid = 1'b0;
    tick(); check_cmd("rstmid.setx", 24'h0A0028);
    rst = 1'b1;
    #1;
    check("rstmid.start", {31'b0, start}, 32'd0);
    check("rstmid.busy", {31'b0, busy}, 32'd0);
    check("rstmid.out", {8'b0, out}, 32'h0);
    check("rstmid.err", {31'b0, timeout_err}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rstmid.ready", {31'b0, req_ready}, 32'd1);
    check("rstmid.still_idle", {31'b0, busy}, 32'd0);
    drive_put(6'd42, 5'd31, 8'hFF, 8'h80);
    tick();
    req_valid = 1'b0;
    tick();
    check("rstmid.e1_start", {31'b0, start}, 32'd0);
    tick(); check_cmd("rstmid.put_setx", 24'h0A0150);
    tick(); check_cmd("rstmid.put_sety", 24'h0B00F8);
    tick(); check_cmd("rstmid.put_tex", 24'h0C00FF);
    tick(); check_cmd("rstmid.put_pal", 24'h0D0080);
    tick();
    check("rstmid.end_busy", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
